// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes instruction memory word by word
// and holds the core in reset until a frame passes its XOR checksum.
`default_nettype none

module imem_loader #(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [7:0]        word_count
);

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_RUN  = 3'd4
   } state_t;

   state_t      state;
   logic [7:0]  len;
   logic [7:0]  csum;
   logic [1:0]  byte_idx;
   logic [23:0] shreg;
   logic        accept;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_SYNC;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         len        <= '0;
         csum       <= '0;
         byte_idx   <= '0;
         shreg      <= '0;
      end else begin
         in_ready <= 1'b1;
         wr_en    <= 1'b0;
         done     <= 1'b0;
         if (accept) begin
            case (state)
               S_SYNC: begin
                  if (in_data == SYNC_BYTE) begin
                     error <= 1'b0;
                     state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (in_data == 8'd0) begin
                     error <= 1'b1;
                     state <= S_SYNC;
                  end else begin
                     len        <= in_data;
                     csum       <= '0;
                     byte_idx   <= '0;
                     word_count <= '0;
                     state      <= S_DATA;
                  end
               end
               S_DATA: begin
                  csum     <= csum ^ in_data;
                  byte_idx <= byte_idx + 2'd1;
                  shreg    <= {shreg[15:0], in_data};
                  // Word completes on the 4th byte; the write strobe lands on the next cycle.
                  if (byte_idx == 2'd3) begin
                     wr_en      <= 1'b1;
                     wr_addr    <= ADDR_W'(word_count);
                     wr_data    <= {shreg, in_data};
                     word_count <= word_count + 8'd1;
                     if (word_count + 8'd1 == len)
                        state <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  if (in_data == csum) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     state    <= S_RUN;
                  end else begin
                     error <= 1'b1;
                     state <= S_SYNC;
                  end
               end
               S_RUN: begin
                  if (in_data == SYNC_BYTE) begin
                     cpu_hold <= 1'b1;
                     state    <= S_LEN;
                  end
               end
               default: state <= S_SYNC;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame sequences against imem_loader with assertion-based checks.
`default_nettype none

module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [7:0]  word_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_total = 0;
   int retries = 0;
   int last_wr = 0;
   int wr_mark = 0;

   imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr_en) wr_total <= wr_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Holds the byte until accepted; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] b);
      logic ok;
      int tries;
      ok = 1'b0;
      tries = 0;
      while (!ok && tries < 20) begin
         in_valid = 1'b1;
         in_data  = b;
         ok = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      retries += tries - 1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [7:0] addr, input logic gap);
      send(w[31:24]);
      check("wr_en_low_mid_word", {31'd0, wr_en}, 32'd0);
      send(w[23:16]);
      send(w[15:8]);
      send(w[7:0]);
      check("wr_en", {31'd0, wr_en}, 32'd1);
      check("wr_addr", {24'd0, wr_addr}, {24'd0, addr});
      check("wr_data", wr_data, w);
      check("word_count", {24'd0, word_count}, {24'd0, addr} + 32'd1);
      if (gap) check("wr_gap", cyc - last_wr, 32'd4);
      last_wr = cyc;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_word_count", {24'd0, word_count}, 32'd0);
      reset = 1'b1;
      idle();
      check("ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Garbage before sync is dropped
      send(8'h00); send(8'hFF); send(8'h12);
      idle(); idle();
      check("garbage_writes", wr_total, 32'd0);
      check("garbage_error", {31'd0, error}, 32'd0);
      check("garbage_hold", {31'd0, cpu_hold}, 32'd1);

      // Single-word frame, then immediate reload from RUN
      send(8'hA5); send(8'h01);
      send_word(32'h24080005, 8'd0, 1'b0);
      send(8'h29);
      check("f1_done", {31'd0, done}, 32'd1);
      check("f1_hold", {31'd0, cpu_hold}, 32'd0);
      send(8'hA5);
      check("reload_hold", {31'd0, cpu_hold}, 32'd1);
      check("reload_done_gone", {31'd0, done}, 32'd0);
      send(8'h02);
      send_word(32'hCAFEBABE, 8'd0, 1'b0);
      send_word(32'h12345678, 8'd1, 1'b1);
      send(8'h38);
      check("f2_done", {31'd0, done}, 32'd1);
      check("f2_hold", {31'd0, cpu_hold}, 32'd0);
      idle();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("f2_writes", wr_total, 32'd3);

      // Three-word frame streamed continuously
      retries = 0;
      send(8'hA5); send(8'h03);
      send_word(32'h11223344, 8'd0, 1'b0);
      send_word(32'h55667788, 8'd1, 1'b1);
      send_word(32'h99AABBCC, 8'd2, 1'b1);
      send(8'hCC);
      check("f3_done", {31'd0, done}, 32'd1);
      check("f3_hold", {31'd0, cpu_hold}, 32'd0);
      check("f3_no_stall", retries, 32'd0);

      // Same frame with bad checksum (A5 in payload position would be data)
      send(8'hA5); send(8'h03);
      send_word(32'h11223344, 8'd0, 1'b0);
      send_word(32'h55667788, 8'd1, 1'b1);
      send_word(32'h99AABBCC, 8'd2, 1'b1);
      send(8'hCD);
      check("bad_done", {31'd0, done}, 32'd0);
      check("bad_error", {31'd0, error}, 32'd1);
      check("bad_hold", {31'd0, cpu_hold}, 32'd1);
      idle(); idle();
      check("bad_error_sticky", {31'd0, error}, 32'd1);
      check("bad_writes", wr_total, 32'd9);

      // Good frame clears error and releases core; payload contains A5
      send(8'hA5);
      check("sync_clears_error", {31'd0, error}, 32'd0);
      send(8'h01);
      send_word(32'hA5ADBEEF, 8'd0, 1'b0);
      send(8'hA5 ^ 8'hAD ^ 8'hBE ^ 8'hEF);
      check("f4_done", {31'd0, done}, 32'd1);
      check("f4_hold", {31'd0, cpu_hold}, 32'd0);

      // LEN of zero
      idle();
      wr_mark = wr_total;
      send(8'hA5); send(8'h00);
      check("len0_error", {31'd0, error}, 32'd1);
      check("len0_hold", {31'd0, cpu_hold}, 32'd1);
      idle(); idle();
      check("len0_no_write", wr_total, wr_mark);

      // Reset mid-frame after 6 data bytes
      send(8'hA5); send(8'h02);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h0A); send(8'h0B);
      in_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("mid_rst_wr_addr", {24'd0, wr_addr}, 32'd0);
      check("mid_rst_wr_data", wr_data, 32'd0);
      check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
      check("mid_rst_error", {31'd0, error}, 32'd0);
      check("mid_rst_word_count", {24'd0, word_count}, 32'd0);
      reset = 1'b1;
      idle();
      send(8'hA5); send(8'h02);
      send_word(32'h01020304, 8'd0, 1'b0);
      send_word(32'h0A0B0C0D, 8'd1, 1'b1);
      send(8'h04);
      check("f5_done", {31'd0, done}, 32'd1);
      check("f5_hold", {31'd0, cpu_hold}, 32'd0);
      check("f5_word_count", {24'd0, word_count}, 32'd2);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: receives a framed program image over a valid/ready byte interface and writes it word by word into instruction memory.
- It is the writer end of the instruction memory that the single-cycle MIPS core reads through its PC.
- Holds the core in reset (cpu_hold) from reset until a frame passes checksum, then releases it.
- A later frame reloads and re-holds the core.

Parameters:
- ADDR_W, 8, word-address width of instruction memory write port.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  byte source has in_data valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle
- wr_en  out  1  instruction memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address (0-based)
- wr_data  out  32  instruction word
- cpu_hold  out  1  high = keep core in reset
- done  out  1  one-cycle pulse on good frame
- error  out  1  sticky frame error flag
- word_count  out  8  words written in current/last frame

Behaviour:
- Reset (reset==0 at clk edge): state SYNC; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, word_count=0. Internal byte index, length and checksum cleared.
- Memory contents are not cleared; a reset mid-frame leaves partially written words in place and the core held.
- Handshake:
  - A byte is accepted on an edge where in_valid & in_ready.
  - in_ready=1 in every state from the first cycle after reset is released.
  - in_data must hold while in_valid=1 and in_ready=0.
- Frame format: SYNC_BYTE, LEN (N words, 1..255), 4N data bytes big-endian per word (first byte -> bits 31:24), CSUM.
- CSUM must equal the XOR of all 4N data bytes.
- FSM:
  - SYNC: an accepted byte equal to SYNC_BYTE -> LEN and clears error; any other byte is dropped.
  - LEN:
    - N==0 -> error=1, go to SYNC.
    - Otherwise store N, clear checksum, byte index and word_count, then go to DATA.
  - DATA:
    - Shift each accepted byte into the word register; XOR it into the checksum.
    - On the 4th byte of a word, the next cycle has wr_en=1 for exactly one cycle, wr_addr=word_count (before increment), wr_data=assembled word. word_count increments in that same cycle.
    - After word N is accepted -> CSUM.
  - CSUM:
    - Match -> done=1 for one cycle and cpu_hold=0 in the cycle after acceptance; go to RUN.
    - Mismatch -> error=1, cpu_hold stays 1; go to SYNC.
  - RUN:
    - An accepted SYNC_BYTE -> cpu_hold=1 in the next cycle, go to LEN.
    - Other bytes are dropped; cpu_hold stays 0.
- Write latency is fixed at 1 cycle after the 4th byte's accept edge. Back-to-back bytes on consecutive cycles are sustained with no stalls.
- A SYNC_BYTE value inside DATA/LEN/CSUM is treated as payload, not a restart.
- wr_addr wraps modulo 2^ADDR_W when N exceeds memory depth; no error is raised.
- wr_addr/wr_data hold their last values when wr_en=0.
- If done and a new SYNC_BYTE coincide in RUN on consecutive cycles, cpu_hold goes 0 for one cycle then 1. The core sees one cycle of release.

Test Plan:
- Reset then frame A5,01,24,08,00,05,CSUM=29 -> wr_en one cycle with wr_addr=0, wr_data=32'h24080005; done pulse; cpu_hold 1->0; word_count=1.
- Frame of N=3 words streamed with in_valid continuous -> three wr_en pulses at addr 0,1,2 each 4 cycles apart; in_ready never drops; done after CSUM.
- Same frame with CSUM byte off by one -> words written, error=1, done never pulses, cpu_hold stays 1, state SYNC; a following good frame clears error and releases the core.
- LEN=00 -> error=1, no wr_en, back to SYNC. Garbage bytes 00,FF,12 before A5 -> ignored, with no writes and no error.
- While in RUN, send A5 -> cpu_hold=1 next cycle; reload 2 words; done; cpu_hold=0.
- Assert reset low after 6 data bytes of an N=2 frame -> next cycle all outputs at reset values, cpu_hold=1. After release, a full new frame loads correctly from addr 0.
